// File: rtl/mips_pkg.sv
// Shared encodings and entry type for the MIPS destination/result tracker.
package mips_pkg;

    // Write-back register selection resolved at issue.
    typedef enum logic [1:0] {
        DST_RT   = 2'd0,
        DST_RD   = 2'd1,
        DST_RA   = 2'd2,
        DST_NONE = 2'd3
    } dst_sel_e;

    // Where the result value comes from; the reserved code behaves as ALU.
    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_PC8  = 2'd2,
        SRC_RSVD = 2'd3
    } res_src_e;

    localparam int unsigned REG_RA = 31;
    localparam int unsigned TNEW_W = 2;

    // Width-independent control part of an in-flight entry.
    typedef struct packed {
        logic              valid;
        res_src_e          src;
        logic [TNEW_W-1:0] tnew;
    } entry_ctrl_t;

    // Remaining latency after one stage of travel, never below zero.
    function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : (t - 1'b1);
    endfunction

endpackage

// File: rtl/dest_result_stage.sv
// One tracker stage: entry register with late-result merge and Tnew countdown.
module dest_result_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 5,
    parameter bit          DEC_TNEW = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  entry_ctrl_t       ctrl_i,
    input  logic [REG_AW-1:0] a3_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              merge_en_i,
    input  logic [DATA_W-1:0] merge_data_i,
    output entry_ctrl_t       ctrl_o,
    output logic [REG_AW-1:0] a3_o,
    output logic [DATA_W-1:0] data_o
);

    entry_ctrl_t       ctrl_d, ctrl_q;
    logic [REG_AW-1:0] a3_d, a3_q;
    logic [DATA_W-1:0] data_d, data_q;

    // Next entry: incoming entry, with a result merged in and Tnew aged by one stage.
    always_comb begin
        ctrl_d = ctrl_i;
        a3_d   = a3_i;
        data_d = merge_en_i ? merge_data_i : data_i;
        if (DEC_TNEW) begin
            ctrl_d.tnew = tnew_dec(ctrl_i.tnew);
        end
    end

    // Entry register, cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ctrl_q <= '0;
            a3_q   <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            a3_q   <= a3_d;
            data_q <= data_d;
        end
    end

    assign ctrl_o = ctrl_q;
    assign a3_o   = a3_q;
    assign data_o = data_q;

endmodule

// File: rtl/dest_result_pipe.sv
// Destination/result tracker for the 5-stage MIPS pipeline.
// Optional feature: define DEST_RESULT_PIPE_WB_BYPASS_EN to keep the previous
// write-back (addr, data) as a lowest-priority forwarding source.
// DEPTH must be at least 3 (stage 0=E, 1=M, 2=W).
module dest_result_pipe
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 3
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic                   d_valid_i,
    input  logic [REG_AW-1:0]      d_rt_i,
    input  logic [REG_AW-1:0]      d_rd_i,
    input  logic [1:0]             d_dst_sel_i,
    input  logic [1:0]             d_res_src_i,
    input  logic [DATA_W-1:0]      d_pc_i,
    input  logic [1:0]             d_tnew_i,
    input  logic [DATA_W-1:0]      e_alu_result_i,
    input  logic [DATA_W-1:0]      m_mem_data_i,
    input  logic [1:0][REG_AW-1:0] rd_addr_i,
    input  logic [1:0][1:0]        rd_tuse_i,
    output logic [1:0]             rd_hit_o,
    output logic [1:0][DATA_W-1:0] rd_data_o,
    output logic                   stall_req_o,
    output logic                   wb_we_o,
    output logic [REG_AW-1:0]      wb_addr_o,
    output logic [DATA_W-1:0]      wb_data_o
);

    entry_ctrl_t       iss_ctrl;
    logic [REG_AW-1:0] iss_a3;
    logic [DATA_W-1:0] iss_data;

    entry_ctrl_t       st_ctrl    [DEPTH];
    logic [REG_AW-1:0] st_a3      [DEPTH];
    logic [DATA_W-1:0] st_data    [DEPTH];
    logic              merge_en   [DEPTH];
    logic [DATA_W-1:0] merge_data [DEPTH];

    logic [TNEW_W-1:0] win_tnew   [2];

    // Build the stage-0 entry from D; stall or flush or no issue gives a bubble.
    always_comb begin
        iss_ctrl = '0;
        iss_a3   = '0;
        iss_data = '0;
        if (d_valid_i && !stall_i && !flush_i) begin
            iss_ctrl.valid = 1'b1;
            iss_ctrl.tnew  = d_tnew_i;
            unique case (d_dst_sel_i)
                DST_RT:   iss_a3 = d_rt_i;
                DST_RD:   iss_a3 = d_rd_i;
                DST_RA:   iss_a3 = REG_AW'(REG_RA);
                DST_NONE: iss_a3 = '0;
            endcase
            unique case (d_res_src_i)
                SRC_MEM: iss_ctrl.src = SRC_MEM;
                SRC_PC8: begin
                    // Link value is known at issue, so it is ready immediately.
                    iss_ctrl.src  = SRC_PC8;
                    iss_ctrl.tnew = '0;
                    iss_data      = d_pc_i + DATA_W'(8);
                end
                default: iss_ctrl.src = SRC_ALU;
            endcase
        end
    end

    // Late results: ALU output joins on the E->M shift, load data on M->W.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            merge_en[k]   = 1'b0;
            merge_data[k] = '0;
        end
        merge_en[1]   = st_ctrl[0].valid && (st_ctrl[0].src == SRC_ALU);
        merge_data[1] = e_alu_result_i;
        merge_en[2]   = st_ctrl[1].valid && (st_ctrl[1].src == SRC_MEM);
        merge_data[2] = m_mem_data_i;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        entry_ctrl_t       in_ctrl;
        logic [REG_AW-1:0] in_a3;
        logic [DATA_W-1:0] in_data;

        if (k == 0) begin : g_head
            assign in_ctrl = iss_ctrl;
            assign in_a3   = iss_a3;
            assign in_data = iss_data;
        end else begin : g_tail
            assign in_ctrl = st_ctrl[k-1];
            assign in_a3   = st_a3[k-1];
            assign in_data = st_data[k-1];
        end

        dest_result_stage #(
            .DATA_W   (DATA_W),
            .REG_AW   (REG_AW),
            .DEC_TNEW (k != 0)
        ) u_stage (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .ctrl_i       (in_ctrl),
            .a3_i         (in_a3),
            .data_i       (in_data),
            .merge_en_i   (merge_en[k]),
            .merge_data_i (merge_data[k]),
            .ctrl_o       (st_ctrl[k]),
            .a3_o         (st_a3[k]),
            .data_o       (st_data[k])
        );
    end

    // Register-file write port driven straight from the last stage.
    assign wb_we_o   = st_ctrl[DEPTH-1].valid && (st_a3[DEPTH-1] != '0);
    assign wb_addr_o = st_a3[DEPTH-1];
    assign wb_data_o = st_data[DEPTH-1];

`ifdef DEST_RESULT_PIPE_WB_BYPASS_EN
    logic              bp_we_q;
    logic [REG_AW-1:0] bp_addr_q;
    logic [DATA_W-1:0] bp_data_q;

    // Remember the write issued to the register file on the previous cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bp_we_q   <= 1'b0;
            bp_addr_q <= '0;
            bp_data_q <= '0;
        end else begin
            bp_we_q   <= wb_we_o;
            bp_addr_q <= wb_addr_o;
            bp_data_q <= wb_data_o;
        end
    end
`endif

    // Forwarding/stall query: scan oldest to youngest so the youngest match wins.
    always_comb begin
        rd_hit_o    = '0;
        rd_data_o   = '0;
        stall_req_o = 1'b0;
        for (int p = 0; p < 2; p++) begin
            win_tnew[p] = '0;
`ifdef DEST_RESULT_PIPE_WB_BYPASS_EN
            // bp_we_q already implies a non-zero address.
            if (bp_we_q && (bp_addr_q == rd_addr_i[p])) begin
                rd_hit_o[p]  = 1'b1;
                rd_data_o[p] = bp_data_q;
            end
`endif
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (st_ctrl[k].valid && (st_a3[k] != '0) && (st_a3[k] == rd_addr_i[p])) begin
                    rd_hit_o[p]  = 1'b1;
                    rd_data_o[p] = st_data[k];
                    win_tnew[p]  = st_ctrl[k].tnew;
                end
            end
            if (rd_hit_o[p] && (win_tnew[p] > rd_tuse_i[p])) begin
                stall_req_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dest_result_pipe.sv
// Self-checking bench for dest_result_pipe: directed vector table followed by
// randomized traffic compared against a queue-based reference model.
module tb_dest_result_pipe;

    localparam int DEPTH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, stall, flush, d_valid;
    logic [4:0]      d_rt, d_rd;
    logic [1:0]      d_dst_sel, d_res_src, d_tnew;
    logic [31:0]     d_pc, e_alu, m_mem;
    logic [1:0][4:0] rd_addr;
    logic [1:0][1:0] rd_tuse;
    logic [1:0]      rd_hit;
    logic [1:0][31:0] rd_data;
    logic            stall_req, wb_we;
    logic [4:0]      wb_addr;
    logic [31:0]     wb_data;

    int n_run  = 0;
    int n_fail = 0;

    dest_result_pipe #(
        .DATA_W (32),
        .REG_AW (5),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .stall_i        (stall),
        .flush_i        (flush),
        .d_valid_i      (d_valid),
        .d_rt_i         (d_rt),
        .d_rd_i         (d_rd),
        .d_dst_sel_i    (d_dst_sel),
        .d_res_src_i    (d_res_src),
        .d_pc_i         (d_pc),
        .d_tnew_i       (d_tnew),
        .e_alu_result_i (e_alu),
        .m_mem_data_i   (m_mem),
        .rd_addr_i      (rd_addr),
        .rd_tuse_i      (rd_tuse),
        .rd_hit_o       (rd_hit),
        .rd_data_o      (rd_data),
        .stall_req_o    (stall_req),
        .wb_we_o        (wb_we),
        .wb_addr_o      (wb_addr),
        .wb_data_o      (wb_data)
    );

    typedef struct {
        logic        rst, stl, fls, dv;
        logic [4:0]  rt, rd;
        logic [1:0]  dsel, src, tnew;
        logic [31:0] pc, alu, mem;
        logic [4:0]  a0, a1;
        logic [1:0]  u0, u1;
        bit          chk;
        logic        eh0, eh1, es, ewe;
        logic [31:0] ed0, ed1, ewd;
        logic [4:0]  ewa;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t idle();
        vec_t v;
        v.rst = 0; v.stl = 0; v.fls = 0; v.dv = 0;
        v.rt = 0; v.rd = 0; v.dsel = 0; v.src = 0; v.tnew = 0;
        v.pc = 0; v.alu = 32'hA1A1_A1A1; v.mem = 32'h5E5E_5E5E;
        v.a0 = 0; v.a1 = 0; v.u0 = 0; v.u1 = 0;
        v.chk = 0; v.eh0 = 0; v.eh1 = 0; v.es = 0; v.ewe = 0;
        v.ed0 = 0; v.ed1 = 0; v.ewd = 0; v.ewa = 0;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        reset = v.rst; stall = v.stl; flush = v.fls; d_valid = v.dv;
        d_rt = v.rt; d_rd = v.rd; d_dst_sel = v.dsel; d_res_src = v.src; d_tnew = v.tnew;
        d_pc = v.pc; e_alu = v.alu; m_mem = v.mem;
        rd_addr[0] = v.a0; rd_addr[1] = v.a1; rd_tuse[0] = v.u0; rd_tuse[1] = v.u1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // pipe[k] is the instruction currently k stages past issue (0 = E).
    typedef struct {
        bit          valid;
        int unsigned a3;
        int unsigned src;
        logic [31:0] data;
        int          tnew0;
    } m_ent_t;

    m_ent_t      pipe[$];
    bit          bp_v;
    int unsigned bp_a;
    logic [31:0] bp_d;

    function automatic m_ent_t bubble();
        m_ent_t e;
        e.valid = 0; e.a3 = 0; e.src = 0; e.data = 0; e.tnew0 = 0;
        return e;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        m_ent_t e, last;
        if (reset) begin
            pipe.delete();
            for (int i = 0; i < DEPTH; i++) pipe.push_back(bubble());
            bp_v = 0; bp_a = 0; bp_d = 0;
            return;
        end
        last = pipe[DEPTH-1];
        bp_v = last.valid && (last.a3 != 0);
        bp_a = last.a3;
        bp_d = last.data;
        if (pipe[0].valid && pipe[0].src == 0) begin
            e = pipe[0]; e.data = e_alu; pipe[0] = e;
        end
        if (pipe[1].valid && pipe[1].src == 1) begin
            e = pipe[1]; e.data = m_mem; pipe[1] = e;
        end
        void'(pipe.pop_back());
        e = bubble();
        if (d_valid && !stall && !flush) begin
            e.valid = 1;
            case (d_dst_sel)
                2'd0:    e.a3 = d_rt;
                2'd1:    e.a3 = d_rd;
                2'd2:    e.a3 = 31;
                default: e.a3 = 0;
            endcase
            e.src   = (d_res_src == 2'd3) ? 0 : d_res_src;
            e.tnew0 = d_tnew;
            if (d_res_src == 2'd2) begin
                e.data  = d_pc + 32'd8;
                e.tnew0 = 0;
            end
        end
        pipe.push_front(e);
    endtask

    // Compare every DUT output with what the model predicts right now.
    task automatic model_check(input int cyc);
        bit          h, st;
        logic [31:0] d;
        int          tn;
        m_ent_t      last;
        st = 0;
        for (int p = 0; p < 2; p++) begin
            h = 0; d = 0; tn = 0;
            for (int k = 0; k < DEPTH; k++) begin
                if (!h && pipe[k].valid && pipe[k].a3 != 0 && pipe[k].a3 == rd_addr[p]) begin
                    h  = 1;
                    d  = pipe[k].data;
                    tn = (pipe[k].tnew0 > k) ? pipe[k].tnew0 - k : 0;
                end
            end
`ifdef DEST_RESULT_PIPE_WB_BYPASS_EN
            if (!h && bp_v && bp_a == rd_addr[p]) begin
                h = 1; d = bp_d; tn = 0;
            end
`endif
            if (h && tn > int'(rd_tuse[p])) st = 1;
            chk($sformatf("rnd%0d rd_hit[%0d]", cyc, p), rd_hit[p], h);
            chk($sformatf("rnd%0d rd_data[%0d]", cyc, p), rd_data[p], d);
        end
        last = pipe[DEPTH-1];
        chk($sformatf("rnd%0d stall_req", cyc), stall_req, st);
        chk($sformatf("rnd%0d wb_we", cyc), wb_we, last.valid && last.a3 != 0);
        chk($sformatf("rnd%0d wb_addr", cyc), wb_addr, last.a3);
        chk($sformatf("rnd%0d wb_data", cyc), wb_data, last.data);
    endtask

    // ---------------- directed table ----------------
    task automatic build_table();
        vec_t v;
        // 0: reset
        v = idle(); v.rst = 1; tbl.push_back(v);
        // 1: everything cleared after reset
        v = idle(); v.a0 = 31; v.chk = 1; tbl.push_back(v);
        // 2: jal at PC 0x3000 (d_tnew ignored for PC+8)
        v = idle(); v.dv = 1; v.dsel = 2; v.src = 2; v.pc = 32'h3000; v.tnew = 3;
        v.a0 = 31; v.chk = 1; tbl.push_back(v);
        // 3,4: $31 forwarded from E then M
        v = idle(); v.a0 = 31; v.chk = 1; v.eh0 = 1; v.ed0 = 32'h3008; tbl.push_back(v);
        tbl.push_back(v);
        // 5: write-back DEPTH cycles after issue
        v.ewe = 1; v.ewa = 31; v.ewd = 32'h3008; tbl.push_back(v);
        // 6: one cycle after write-back
        v = idle(); v.a0 = 31; v.chk = 1;
`ifdef DEST_RESULT_PIPE_WB_BYPASS_EN
        v.eh0 = 1; v.ed0 = 32'h3008;
`endif
        tbl.push_back(v);
        // 7: lw $8
        v = idle(); v.dv = 1; v.dsel = 0; v.rt = 8; v.rd = 3; v.src = 1; v.tnew = 2;
        v.chk = 1; tbl.push_back(v);
        // 8,9: use of $8 with Tuse 0 while held
        v = idle(); v.stl = 1; v.a0 = 8; v.chk = 1; v.eh0 = 1; v.es = 1; tbl.push_back(v);
        v.mem = 32'hDEAD_BEEF; tbl.push_back(v);
        // 10: load data now forwardable
        v = idle(); v.a0 = 8; v.chk = 1; v.eh0 = 1; v.ed0 = 32'hDEAD_BEEF;
        v.ewe = 1; v.ewa = 8; v.ewd = 32'hDEAD_BEEF; tbl.push_back(v);
        // 11,12: addu $9 twice
        v = idle(); v.dv = 1; v.dsel = 1; v.rd = 9; v.rt = 2; v.tnew = 1; v.a0 = 9;
        v.chk = 1; tbl.push_back(v);
        v.alu = 32'h11; v.u0 = 1; v.eh0 = 1; tbl.push_back(v);
        // 13: younger in E (Tnew 1) wins; port 0 Tuse 0 stalls, port 1 Tuse 2 does not
        v = idle(); v.alu = 32'h22; v.a0 = 9; v.a1 = 9; v.u1 = 2; v.chk = 1;
        v.eh0 = 1; v.eh1 = 1; v.es = 1; tbl.push_back(v);
        // 14: both in flight, younger value returned
        v = idle(); v.a0 = 9; v.a1 = 9; v.chk = 1; v.eh0 = 1; v.ed0 = 32'h22;
        v.eh1 = 1; v.ed1 = 32'h22; v.ewe = 1; v.ewa = 9; v.ewd = 32'h11; tbl.push_back(v);
        // 15: issue a write to $0 (rt differs, rd selected)
        v = idle(); v.dv = 1; v.dsel = 1; v.rd = 0; v.rt = 9; v.tnew = 1; v.a1 = 9;
        v.chk = 1; v.eh1 = 1; v.ed1 = 32'h22; v.ewe = 1; v.ewa = 9; v.ewd = 32'h22;
        tbl.push_back(v);
        // 16: $0 never hits
        v = idle(); v.alu = 32'h44; v.chk = 1; tbl.push_back(v);
        // 17: issue addu $11
        v = idle(); v.dv = 1; v.dsel = 1; v.rd = 11; v.tnew = 1; v.chk = 1; tbl.push_back(v);
        // 18: stall+flush with an issue; $0 writer reaches W without writing
        v = idle(); v.stl = 1; v.fls = 1; v.dv = 1; v.dsel = 1; v.rd = 10; v.tnew = 1;
        v.alu = 32'h66; v.chk = 1; v.ewd = 32'h44; tbl.push_back(v);
        // 19: $10 was dropped, $11 advanced unchanged
        v = idle(); v.a0 = 10; v.a1 = 11; v.chk = 1; v.eh1 = 1; v.ed1 = 32'h66;
        tbl.push_back(v);
        // 20: $11 writes back
        v.ewe = 1; v.ewa = 11; v.ewd = 32'h66; tbl.push_back(v);
        // 21: one cycle after write-back of $11
        v = idle(); v.a1 = 11; v.chk = 1;
`ifdef DEST_RESULT_PIPE_WB_BYPASS_EN
        v.eh1 = 1; v.ed1 = 32'h66;
`endif
        tbl.push_back(v);
        // 22: issue $12
        v = idle(); v.dv = 1; v.dsel = 0; v.rt = 12; v.tnew = 1; v.chk = 1; tbl.push_back(v);
        // 23: reset while $12 is in E and $13 tries to issue
        v = idle(); v.rst = 1; v.dv = 1; v.dsel = 0; v.rt = 13; v.tnew = 1;
        v.a0 = 12; v.a1 = 13; v.chk = 1; v.eh0 = 1; v.es = 1; tbl.push_back(v);
        // 24: everything discarded
        v = idle(); v.a0 = 12; v.a1 = 13; v.chk = 1; tbl.push_back(v);
    endtask

    initial begin
        vec_t v;
        apply(idle());
        build_table();
        for (int i = 0; i < DEPTH; i++) pipe.push_back(bubble());

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            apply(tbl[i]);
            @(negedge clk);
            if (tbl[i].chk) begin
                chk($sformatf("row%0d rd_hit[0]", i), rd_hit[0], tbl[i].eh0);
                chk($sformatf("row%0d rd_data[0]", i), rd_data[0], tbl[i].ed0);
                chk($sformatf("row%0d rd_hit[1]", i), rd_hit[1], tbl[i].eh1);
                chk($sformatf("row%0d rd_data[1]", i), rd_data[1], tbl[i].ed1);
                chk($sformatf("row%0d stall_req", i), stall_req, tbl[i].es);
                chk($sformatf("row%0d wb_we", i), wb_we, tbl[i].ewe);
                chk($sformatf("row%0d wb_addr", i), wb_addr, tbl[i].ewa);
                chk($sformatf("row%0d wb_data", i), wb_data, tbl[i].ewd);
            end
            model_step();
        end

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            v = idle();
            v.rst  = ($urandom_range(63) == 0);
            v.stl  = ($urandom_range(4) == 0);
            v.fls  = ($urandom_range(7) == 0);
            v.dv   = ($urandom_range(3) != 0);
            v.rt   = 5'($urandom_range(7));
            v.rd   = 5'($urandom_range(7));
            v.dsel = 2'($urandom_range(3));
            v.src  = 2'($urandom_range(3));
            v.tnew = 2'($urandom_range(3));
            v.pc   = $urandom;
            v.alu  = $urandom;
            v.mem  = $urandom;
            v.a0   = ($urandom_range(9) == 0) ? 5'd31 : 5'($urandom_range(7));
            v.a1   = ($urandom_range(9) == 0) ? 5'd31 : 5'($urandom_range(7));
            v.u0   = 2'($urandom_range(3));
            v.u1   = 2'($urandom_range(3));
            apply(v);
            @(negedge clk);
            model_check(c);
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
